pc_fetch_stage: RTL and testbench

Instruction-fetch stage for the single-cycle/pipelined MIPS core. Owns the program counter, drives the word address into the instruction memory, and captures the returned instruction into the IF/ID pipeline register. Sits directly upstream of the instruction memory and feeds the decode stage. Supports stall, redirect from branch/jump resolution, and optional in-fetch jump predecode.

---
 rtl/pc_fetch_stage.sv | 87 ++++++++
 tb/tb_pc_fetch_stage.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: owns the word-addressed PC, drives the instruction memory
// and captures the returned word into the IF/ID register. Optional macro: FETCH_JUMP_PREDECODE_EN.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] read_addr,
  input  logic [31:0] instruction,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus1,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_plus1_q, ifid_pc_plus1_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] pc_plus1;
  logic        is_jump;

  assign pc_plus1 = pc_q + 32'd1;

`ifdef FETCH_JUMP_PREDECODE_EN
  localparam logic [5:0] OPC_J = 6'b000010;
  assign is_jump = (instruction[31:26] == OPC_J);
`else
  assign is_jump = 1'b0;
`endif

  // Priority below reset: redirect > stall > predecoded jump > sequential.
  always_comb begin
    pc_d            = pc_q;
    ifid_valid_d    = ifid_valid_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_plus1_d = ifid_pc_plus1_q;
    fetch_count_d   = fetch_count_q;
    if (redirect_valid) begin
      pc_d            = redirect_target;
      ifid_valid_d    = 1'b0;
      ifid_instr_d    = 32'd0;
      ifid_pc_plus1_d = 32'd0;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (is_jump) begin
      // The jump slot itself is consumed as a bubble; it never reaches decode.
      pc_d            = {pc_plus1[31:26], instruction[25:0]};
      ifid_valid_d    = 1'b0;
      ifid_instr_d    = 32'd0;
      ifid_pc_plus1_d = 32'd0;
    end else begin
      pc_d            = pc_plus1;
      ifid_valid_d    = 1'b1;
      ifid_instr_d    = instruction;
      ifid_pc_plus1_d = pc_plus1;
      fetch_count_d   = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q            <= RESET_PC;
      ifid_valid_q    <= 1'b0;
      ifid_instr_q    <= 32'd0;
      ifid_pc_plus1_q <= 32'd0;
      fetch_count_q   <= 32'd0;
    end else begin
      pc_q            <= pc_d;
      ifid_valid_q    <= ifid_valid_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_plus1_q <= ifid_pc_plus1_d;
      fetch_count_q   <= fetch_count_d;
    end
  end

  assign read_addr     = pc_q;
  assign ifid_valid    = ifid_valid_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc_plus1 = ifid_pc_plus1_q;
  assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed-vector bench for pc_fetch_stage; the instruction memory holds
// 0x20080020 + addr[5:0], except address 17 which holds j 14 (0x0800000E).
module tb_pc_fetch_stage;

  localparam int W = 129; // {read_addr, ifid_valid, ifid_instr, ifid_pc_plus1, fetch_count}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic [31:0] read_addr;
  logic [31:0] instruction;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus1;
  logic [31:0] fetch_count;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic done = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  pc_fetch_stage #(.RESET_PC(32'd0)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .read_addr       (read_addr),
    .instruction     (instruction),
    .ifid_valid      (ifid_valid),
    .ifid_instr      (ifid_instr),
    .ifid_pc_plus1   (ifid_pc_plus1),
    .fetch_count     (fetch_count)
  );

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a[5:0] == 6'd17) return 32'h0800000E;
    return 32'h20080020 + {26'd0, a[5:0]};
  endfunction

  assign instruction = imem(read_addr);

  // driver: apply one cycle of inputs and queue the state expected after the next edge
  task automatic drive(input logic r, input logic s, input logic rv, input logic [31:0] tgt,
                       input logic [31:0] e_ra, input logic e_v, input logic [31:0] e_instr,
                       input logic [31:0] e_p1, input logic [31:0] e_cnt);
    @(negedge clk);
    rst             = r;
    stall           = s;
    redirect_valid  = rv;
    redirect_target = tgt;
    exp_q.push_back({e_ra, e_v, e_instr, e_p1, e_cnt});
  endtask

  task automatic seq(input logic [31:0] e_ra, input logic [31:0] e_instr,
                     input logic [31:0] e_p1, input logic [31:0] e_cnt);
    drive(1'b0, 1'b0, 1'b0, 32'd0, e_ra, 1'b1, e_instr, e_p1, e_cnt);
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
  endtask

  // scoreboard monitor: samples 1 time unit after every rising edge
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check32("read_addr",     read_addr,            e[128:97]);
        check32("ifid_valid",    {31'd0, ifid_valid},  {31'd0, e[96]});
        check32("ifid_instr",    ifid_instr,           e[95:64]);
        check32("ifid_pc_plus1", ifid_pc_plus1,        e[63:32]);
        check32("fetch_count",   fetch_count,          e[31:0]);
      end
    end
  end

`ifdef FETCH_JUMP_PREDECODE_EN
  localparam logic [31:0] CNT_AFTER_J = 32'd14;
`else
  localparam logic [31:0] CNT_AFTER_J = 32'd15;
`endif

  // stimulus
  initial begin
    // reset
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    // sequential fetch from 0
    seq(32'd1, 32'h20080020, 32'd1, 32'd1);
    seq(32'd2, 32'h20080021, 32'd2, 32'd2);
    seq(32'd3, 32'h20080022, 32'd3, 32'd3);
    seq(32'd4, 32'h20080023, 32'd4, 32'd4);
    seq(32'd5, 32'h20080024, 32'd5, 32'd5);
    seq(32'd6, 32'h20080025, 32'd6, 32'd6);
    // stall at PC=6 for three cycles
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd6, 1'b1, 32'h20080025, 32'd6, 32'd6);
    seq(32'd7, 32'h20080026, 32'd7, 32'd7);
    seq(32'd8, 32'h20080027, 32'd8, 32'd8);
    seq(32'd9, 32'h20080028, 32'd9, 32'd9);
    // redirect at PC=9 to 18
    drive(1'b0, 1'b0, 1'b1, 32'd18, 32'd18, 1'b0, 32'd0, 32'd0, 32'd9);
    seq(32'd19, 32'h20080032, 32'd19, 32'd10);
    // stall and redirect together: redirect wins
    drive(1'b0, 1'b1, 1'b1, 32'd14, 32'd14, 1'b0, 32'd0, 32'd0, 32'd10);
    seq(32'd15, 32'h2008002E, 32'd15, 32'd11);
    seq(32'd16, 32'h2008002F, 32'd16, 32'd12);
    seq(32'd17, 32'h20080030, 32'd17, 32'd13);
    // PC=17 fetches j 14
`ifdef FETCH_JUMP_PREDECODE_EN
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd14, 1'b0, 32'd0, 32'd0, 32'd13);
    seq(32'd15, 32'h2008002E, 32'd15, 32'd14);
`else
    seq(32'd18, 32'h0800000E, 32'd18, 32'd14);
    seq(32'd19, 32'h20080032, 32'd19, 32'd15);
`endif
    // move to PC=12, then reset with stall high and with redirect high
    drive(1'b0, 1'b0, 1'b1, 32'd12, 32'd12, 1'b0, 32'd0, 32'd0, CNT_AFTER_J);
    drive(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b1, 32'd30, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    seq(32'd1, 32'h20080020, 32'd1, 32'd1);
    // PC wrap at 0xFFFFFFFF
    drive(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0, 32'd0, 32'd1);
    seq(32'd0, 32'h2008005F, 32'd0, 32'd2);
    seq(32'd1, 32'h20080020, 32'd1, 32'd3);
    done = 1'b1;
  end

  // final report
  initial begin
    int budget;
    budget = 0;
    while (!(done && exp_q.size() == 0) && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0 || !done) begin
      n_checks++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
